mips_muldiv: RTL and testbench

Iterative multiply/divide unit with architectural HI/LO registers for the 5-stage MIPS pipeline. It executes MULT, MULTU, DIV, DIVU, MTHI and MTLO issued from the execute stage and holds `busy` while an operation is in flight, so the hazard logic can stall dependent MFHI/MFLO. Operand width is parametrised, so one block serves the 32-bit core and narrower test configurations.

---
 rtl/mips_muldiv_pkg.sv | 25 ++
 rtl/mips_muldiv_if.sv | 20 ++
 rtl/mips_muldiv_sign.sv | 40 ++++
 rtl/mips_muldiv.sv | 178 +++++++++++++++++
 tb/tb_mips_muldiv.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/mips_muldiv_pkg.sv
// mips_muldiv_pkg: shared constants for the MIPS multiply/divide unit.
//   - op-code encodings issued from the execute stage
//   - FSM state encodings (IDLE, CALC, FIX)
//   - helper giving the iteration-counter width for a given operand width
package mips_muldiv_pkg;

  // Operation codes on the 3-bit op bus; 110 and 111 are ignored
  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  // FSM state encodings
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;

  // Counter must hold the value WIDTH itself
  function automatic int unsigned cnt_w(input int unsigned w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/mips_muldiv_if.sv
// mips_muldiv_if: issue/result bundle between the execute stage and the
// multiply/divide unit.
//   master (core)  : drives start, op, flush, a, b; observes busy, done, hi, lo
//   slave  (muldiv): the reverse
interface mips_muldiv_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic             flush;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (output start, op, flush, a, b, input  busy, done, hi, lo);
  modport slave  (input  start, op, flush, a, b, output busy, done, hi, lo);
endinterface

// File: rtl/mips_muldiv_sign.sv
// mips_muldiv_sign: combinational sign helpers for the muldiv unit.
//   a, b, sgn           : raw operands and signed-op flag (issue time)
//   abs_a, abs_b        : magnitudes (raw value for unsigned ops)
//   res                 : {upper, lower} raw result from the iteration
//   neg_full            : negate the whole double-width product
//   neg_hi, neg_lo      : negate the halves independently (remainder/quotient)
//   res_fix             : sign-corrected result, split into HI/LO by the caller
module mips_muldiv_sign #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               sgn,
  output logic [WIDTH-1:0]   abs_a,
  output logic [WIDTH-1:0]   abs_b,
  input  logic [2*WIDTH-1:0] res,
  input  logic               neg_full,
  input  logic               neg_hi,
  input  logic               neg_lo,
  output logic [2*WIDTH-1:0] res_fix
);

  logic [WIDTH-1:0] hi_w;
  logic [WIDTH-1:0] lo_w;

  // Magnitudes wrap, so |MIN| stays MIN and is treated as unsigned 2^(W-1)
  always_comb begin
    abs_a = (sgn && a[WIDTH-1]) ? -a : a;
    abs_b = (sgn && b[WIDTH-1]) ? -b : b;
  end

  // Result fix-up: full negate for products, per-half for quotient/remainder
  always_comb begin
    hi_w = neg_hi ? -res[2*WIDTH-1:WIDTH] : res[2*WIDTH-1:WIDTH];
    lo_w = neg_lo ? -res[WIDTH-1:0]       : res[WIDTH-1:0];
    if (neg_full) res_fix = -res;
    else          res_fix = {hi_w, lo_w};
  end

endmodule

// File: rtl/mips_muldiv.sv
// mips_muldiv: iterative multiply/divide unit with HI/LO registers.
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of mips_muldiv_if
//              start/op/flush/a/b in; busy/done/hi/lo out (all registered)
// Multiply is shift-add and divide is restoring, one bit per cycle; a
// mul/div takes WIDTH cycles in CALC plus one FIX cycle for sign correction.
module mips_muldiv
  import mips_muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input logic          clk,
  input logic          rst,
  mips_muldiv_if.slave bus
);

  localparam int unsigned W2 = 2 * WIDTH;
  localparam int unsigned CW = cnt_w(WIDTH);

  logic [1:0]       state_q;
  logic [1:0]       state_d;
  logic [CW-1:0]    cnt_q;
  logic [W2-1:0]    work_q;     // mul: {partial, multiplier}; div: {rem, quotient}
  logic [WIDTH-1:0] opnd_q;     // mul: multiplicand; div: divisor
  logic             is_div_q;
  logic             neg_full_q;
  logic             neg_hi_q;
  logic             neg_lo_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;

  logic             issue_c;
  logic             is_sgn_c;
  logic             sign_a_c;
  logic             sign_b_c;
  logic             b_zero_c;
  logic [WIDTH-1:0] abs_a_c;
  logic [WIDTH-1:0] abs_b_c;
  logic [W2-1:0]    res_c;
  logic [WIDTH:0]   sum_c;
  logic [WIDTH:0]   cand_c;
  logic [WIDTH-1:0] diff_c;
  logic             ge_c;
  logic [W2-1:0]    mul_nx_c;
  logic [W2-1:0]    div_nx_c;

  // Issue decode; flush suppresses a same-cycle start
  assign issue_c  = (state_q == ST_IDLE) && bus.start && !bus.flush;
  assign is_sgn_c = !bus.op[0];
  assign sign_a_c = is_sgn_c && bus.a[WIDTH-1];
  assign sign_b_c = is_sgn_c && bus.b[WIDTH-1];
  assign b_zero_c = (bus.b == '0);

  mips_muldiv_sign #(.WIDTH(WIDTH)) u_sign (
    .a        (bus.a),
    .b        (bus.b),
    .sgn      (is_sgn_c),
    .abs_a    (abs_a_c),
    .abs_b    (abs_b_c),
    .res      (work_q),
    .neg_full (neg_full_q),
    .neg_hi   (neg_hi_q),
    .neg_lo   (neg_lo_q),
    .res_fix  (res_c)
  );

  // One shift-add multiply step
  always_comb begin
    sum_c    = {1'b0, work_q[W2-1:WIDTH]} + (work_q[0] ? {1'b0, opnd_q} : '0);
    mul_nx_c = {sum_c, work_q[WIDTH-1:1]};
  end

  // One restoring divide step; the low WIDTH bits of the difference are exact
  // whenever the subtraction is kept
  always_comb begin
    cand_c   = {work_q[W2-1:WIDTH], work_q[WIDTH-1]};
    ge_c     = (cand_c >= {1'b0, opnd_q});
    diff_c   = cand_c[WIDTH-1:0] - opnd_q;
    div_nx_c = ge_c ? {diff_c,             work_q[WIDTH-2:0], 1'b1}
                    : {cand_c[WIDTH-1:0], work_q[WIDTH-2:0], 1'b0};
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (issue_c && !bus.op[2]) state_d = ST_CALC;
      ST_CALC: begin
        if (bus.flush)                state_d = ST_IDLE;
        else if (cnt_q == CW'(1))     state_d = ST_FIX;
      end
      ST_FIX:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State, datapath and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      work_q     <= '0;
      opnd_q     <= '0;
      is_div_q   <= 1'b0;
      neg_full_q <= 1'b0;
      neg_hi_q   <= 1'b0;
      neg_lo_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d != ST_IDLE);
      done_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (issue_c) begin
            case (bus.op)
              OP_MULT, OP_MULTU: begin
                opnd_q     <= abs_a_c;
                work_q     <= {{WIDTH{1'b0}}, abs_b_c};
                is_div_q   <= 1'b0;
                neg_full_q <= sign_a_c ^ sign_b_c;
                neg_hi_q   <= 1'b0;
                neg_lo_q   <= 1'b0;
                cnt_q      <= CW'(WIDTH);
              end
              OP_DIV, OP_DIVU: begin
                opnd_q     <= abs_b_c;
                work_q     <= {{WIDTH{1'b0}}, abs_a_c};
                is_div_q   <= 1'b1;
                neg_full_q <= 1'b0;
                // Remainder follows the dividend; with a zero divisor the
                // iteration leaves |a| in the remainder, so this restores a.
                neg_hi_q   <= sign_a_c;
                // Zero divisor keeps the all-ones quotient uncorrected
                neg_lo_q   <= (sign_a_c ^ sign_b_c) && !b_zero_c;
                cnt_q      <= CW'(WIDTH);
              end
              OP_MTHI: begin
                hi_q   <= bus.a;
                done_q <= 1'b1;
              end
              OP_MTLO: begin
                lo_q   <= bus.a;
                done_q <= 1'b1;
              end
              default: ;
            endcase
          end
        end
        ST_CALC: begin
          if (!bus.flush) begin
            work_q <= is_div_q ? div_nx_c : mul_nx_c;
            cnt_q  <= cnt_q - CW'(1);
          end
        end
        ST_FIX: begin
          if (!bus.flush) begin
            hi_q   <= res_c[W2-1:WIDTH];
            lo_q   <= res_c[WIDTH-1:0];
            done_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_mips_muldiv.sv
// tb_mips_muldiv: directed vectors with a result scoreboard for mips_muldiv.
// Issued ops push their expected {hi, lo}; a monitor pops on every done pulse.
module tb_mips_muldiv;
  import mips_muldiv_pkg::*;

  localparam int unsigned W = 32;

  logic clk;
  logic rst;

  mips_muldiv_if #(.WIDTH(W)) bus ();

  mips_muldiv #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;
  logic [63:0]  exp_q [$];
  logic [W-1:0] m_hi;
  logic [W-1:0] m_lo;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h", nm, act, exp);
    end
  endtask

  // Result monitor: every done pulse must match the oldest expectation
  always @(negedge clk) begin : monitor
    logic [63:0] e;
    if (!rst && bus.done === 1'b1) begin
      chk("done_with_busy", 64'(bus.busy), 64'd0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: hi=%h lo=%h", bus.hi, bus.lo);
      end else begin
        e = exp_q.pop_front();
        chk("hi", 64'(bus.hi), 64'(e[63:32]));
        chk("lo", 64'(bus.lo), 64'(e[31:0]));
      end
    end
  end

  task automatic expect_res(input logic [W-1:0] h, input logic [W-1:0] l);
    exp_q.push_back({h, l});
    m_hi = h;
    m_lo = l;
  endtask

  // Called at a negedge; holds start for exactly one rising edge
  task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Returns at the negedge where done is seen, counting busy cycles before it
  task automatic wait_done(output int bc);
    bit seen;
    seen = 1'b0;
    bc   = 0;
    for (int i = 0; i < 100; i++) begin
      if (bus.done === 1'b1) begin
        seen = 1'b1;
        break;
      end
      if (bus.busy === 1'b1) bc++;
      @(negedge clk);
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL done_timeout: no done within 100 cycles");
    end
  endtask

  task automatic run_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] eh, input logic [W-1:0] el);
    int bc;
    expect_res(eh, el);
    issue(op, a, b);
    wait_done(bc);
    chk("busy_cycles", 64'(bc), 64'(W + 1));
    @(negedge clk);
    chk("done_pulse_width", 64'(bus.done), 64'd0);
  endtask

  task automatic mt_op(input logic [2:0] op, input logic [W-1:0] a);
    if (op == OP_MTHI) expect_res(a, m_lo);
    else               expect_res(m_hi, a);
    issue(op, a, '0);
    chk("mt_busy", 64'(bus.busy), 64'd0);
    chk("mt_done", 64'(bus.done), 64'd1);
    @(negedge clk);
    chk("mt_done_pulse", 64'(bus.done), 64'd0);
  endtask

  initial begin
    int bc;
    bit seen_done;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.op    = 3'b000;
    bus.flush = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    m_hi      = '0;
    m_lo      = '0;
    repeat (3) @(negedge clk);
    chk("rst_hi",   64'(bus.hi),   64'd0);
    chk("rst_lo",   64'(bus.lo),   64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Multiply / divide vectors
    run_op(OP_MULT,  32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1);
    run_op(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
    run_op(OP_MULT,  32'h7FFFFFFF, 32'h80000000, 32'hC0000000, 32'h80000000);
    run_op(OP_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op(OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);
    run_op(OP_DIVU,  32'd7,        32'd0,        32'h00000007, 32'hFFFFFFFF);
    run_op(OP_DIV,   32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF);
    run_op(OP_DIVU,  32'd100,      32'd7,        32'h00000002, 32'h0000000E);
    run_op(OP_DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD);

    // Register moves
    mt_op(OP_MTHI, 32'h12345678);
    mt_op(OP_MTLO, 32'hCAFEF00D);

    // Reserved op codes leave state untouched
    issue(3'b110, 32'hFFFF0000, 32'd3);
    chk("rsvd_done", 64'(bus.done), 64'd0);
    chk("rsvd_busy", 64'(bus.busy), 64'd0);
    issue(3'b111, 32'hFFFF0000, 32'd3);
    chk("rsvd_hi", 64'(bus.hi), 64'(m_hi));
    chk("rsvd_lo", 64'(bus.lo), 64'(m_lo));

    // Back-to-back issue in the done cycle
    expect_res(32'd0, 32'd12);
    issue(OP_MULTU, 32'd3, 32'd4);
    wait_done(bc);
    expect_res(32'd2, 32'd2);
    issue(OP_DIVU, 32'd12, 32'd5);
    wait_done(bc);
    chk("b2b_busy_cycles", 64'(bc), 64'(W + 1));
    @(negedge clk);

    // Start while busy is ignored
    expect_res(32'd0, 32'd6);
    issue(OP_MULT, 32'd2, 32'd3);
    repeat (5) @(negedge clk);
    issue(OP_MTHI, 32'hDEADBEEF, '0);
    wait_done(bc);
    chk("ignored_start_busy_cycles", 64'(bc), 64'd27);
    @(negedge clk);

    // Flush on cycle 10 of a multiply
    issue(OP_MULT, 32'd9, 32'd9);
    repeat (9) @(negedge clk);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    chk("flush_busy", 64'(bus.busy), 64'd0);
    seen_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bus.done === 1'b1) seen_done = 1'b1;
      @(negedge clk);
    end
    chk("flush_no_done", 64'(seen_done), 64'd0);
    chk("flush_hi", 64'(bus.hi), 64'(m_hi));
    chk("flush_lo", 64'(bus.lo), 64'(m_lo));

    // Flush and start together in IDLE: nothing issued
    bus.flush = 1'b1;
    issue(OP_MTLO, 32'h11111111, '0);
    bus.flush = 1'b0;
    chk("flush_start_done", 64'(bus.done), 64'd0);
    chk("flush_start_lo",   64'(bus.lo),   64'(m_lo));

    // Reset in the middle of a divide
    issue(OP_DIV, 32'd100, 32'd7);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_hi",   64'(bus.hi),   64'd0);
    chk("midrst_lo",   64'(bus.lo),   64'd0);
    chk("midrst_busy", 64'(bus.busy), 64'd0);
    m_hi = '0;
    m_lo = '0;
    repeat (40) @(negedge clk);

    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
